rvc_fifo: RTL
=============

// Module: rvc_fifo
// PURPOSE
//  Parametrised ready/valid channel controller: generalises the single-slot
//  accept-and-hold controller to a DEPTH-entry, WIDTH-bit elastic buffer.
//  Sits between a producer and a consumer, both using valid/ready handshakes.
//  Adds occupancy reporting, an almost-full flag and a synchronous flush.
// PARAMETERS
//  WIDTH  8  payload width in bits (>=1)
//  DEPTH  4  number of storage slots (>=1, need not be a power of two)
//  AFULL  3  almost_full asserts when count >= AFULL (1..DEPTH)
//  CW     $clog2(DEPTH+1)  count width (derived localparam, not overridable)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous reset, active-low (0 = reset)
//  in_valid     in   1      producer offers in_data
//  in_data      in   WIDTH  producer payload
//  in_ready     out  1      buffer can accept this cycle
//  out_valid    out  1      out_data holds the oldest entry
//  out_data     out  WIDTH  head payload
//  out_ready    in   1      consumer takes head this cycle
//  flush        in   1      synchronous discard of all entries
//  count        out  CW     current occupancy, 0..DEPTH
//  almost_full  out  1      count >= AFULL
// BEHAVIOUR
//  - Reset: rst sampled low at posedge -> count=0, rd/wr pointers=0.
//    While rst is low: in_ready=0, out_valid=0 (combinationally forced).
//    First cycle after release: in_ready=1, out_valid=0, count=0,
//    almost_full=0. Storage contents are not reset; out_data is don't-care
//    while out_valid=0.
//  - Reset mid-operation discards all entries; no handshake completes in a
//    cycle where rst is low.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = rst & (count != DEPTH); out_valid = rst & (count != 0).
//    Both depend only on registered state, so there is no combinational
//    path from out_ready to in_ready or from in_valid to out_valid.
//  - Latency: data pushed into an empty buffer appears on out_data with
//    out_valid=1 on the next cycle. There is no same-cycle bypass.
//  - Ordering: strict FIFO. out_data = mem[rd_ptr].
//  - Pointers advance by 1 on push (wr_ptr) or pop (rd_ptr) and wrap from
//    DEPTH-1 to 0 by explicit compare, not by bit overflow.
//  - Count update: push&!pop -> +1; pop&!push -> -1; both or neither ->
//    unchanged.
//  - Full (count==DEPTH): in_ready=0. A pop that cycle frees a slot, and
//    in_ready=1 on the next cycle.
//  - Empty (count==0): out_ready is ignored.
//  - flush=1 at posedge: count=0 and rd_ptr=wr_ptr=0. Flush overrides any
//    push or pop in the same cycle; neither takes effect. in_ready and
//    out_valid are not gated by flush in that cycle. rst low overrides
//    flush.
//  - DEPTH=1 must behave as a one-slot controller: in_ready drops the cycle
//    after an accept and returns the cycle after the pop.
//  - Producer and consumer must keep in_data/in_valid stable until
//    accepted; the block does not check this.
// TESTING
//  1 Reset: rst=0 for 2 clks, then rst=1 -> in_ready=1, out_valid=0,
//    count=0, almost_full=0. During rst=0, in_ready=0.
//  2 Fill (DEPTH=4, AFULL=3), out_ready=0: push 0x11,0x22,0x33,0x44 ->
//    count goes 1,2,3,4; almost_full=1 from count 3; in_ready=0 at count 4;
//    a 5th in_valid is not accepted and count stays 4.
//  3 Drain: out_ready=1 -> out_data reads 0x11,0x22,0x33,0x44 on consecutive
//    cycles; then out_valid=0 and count=0.
//  4 Simultaneous push+pop: at count=2 hold in_valid=out_ready=1 for 10 clks
//    -> count stays 2 and the data order is preserved across pointer wrap.
//    When full, push+pop -> pop only; in_ready=1 the next cycle.
//  5 Flush with in_valid=out_ready=1 at count=3 -> next cycle count=0,
//    out_valid=0; the flushed-cycle push is not stored.
//  6 Mid-operation reset at count=2 with in_valid=1 -> after release,
//    count=0 and out_valid=0. Repeat tests 1-3 with DEPTH=1 and DEPTH=3
//    (non-power-of-two wrap).

Source files
------------

// File: rtl/rvc_fifo_if.sv
// Ready/valid channel bundle between producer, elastic buffer and consumer.
// The master drives the producer side and takes the consumer side.
interface rvc_fifo_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/rvc_fifo.sv
// DEPTH-entry ready/valid elastic buffer with occupancy, almost-full and flush.
// Handshake outputs depend only on registered state and rst.
module rvc_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   parameter  int AFULL = 3,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   rvc_fifo_if.slave     bus,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic          almost_full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push, pop;

   assign bus.in_ready  = rst & (count_q != CW'(DEPTH));
   assign bus.out_valid = rst & (count_q != '0);
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign count         = count_q;
   assign almost_full   = (count_q >= CW'(AFULL));

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         // flush wins over any same-cycle handshake
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)
            count_d = count_q + 1'b1;
         else if (pop && !push)
            count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage is intentionally left out of reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule
